// File: rtl/layer22_argmax_scorer.sv
// Sequential argmax over a 22-entry score vector: one comparison per cycle,
// a one-hot training target for the labelled class, and saturating hit/sample counters.
module layer22_argmax_scorer #(
  parameter int unsigned    W         = 8,
  parameter logic [W-1:0]   TARGET_HI = '1,
  parameter logic [W-1:0]   TARGET_LO = '0,
  parameter logic [15:0]    SAT_LIMIT = 16'hFFFF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [21:0][W-1:0]  scores,
  input  logic [4:0]          label,
  input  logic                clear_stats,
  output logic                busy,
  output logic                done,
  output logic [4:0]          pred_idx,
  output logic [W-1:0]        pred_val,
  output logic                correct,
  output logic [21:0][W-1:0]  expected_out,
  output logic                learn_valid,
  output logic [15:0]         hit_count,
  output logic [15:0]         sample_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e               state_q, state_d;
  logic [21:0][W-1:0]   cap_q, cap_d;
  logic [4:0]           label_q, label_d;
  logic [W-1:0]         best_val_q, best_val_d;
  logic [4:0]           best_idx_q, best_idx_d;
  logic [4:0]           k_q, k_d;
  logic [4:0]           pred_idx_q, pred_idx_d;
  logic [W-1:0]         pred_val_q, pred_val_d;
  logic                 correct_q, correct_d;
  logic [21:0][W-1:0]   exp_q, exp_d;
  logic                 lv_q, lv_d;
  logic [15:0]          hit_q, hit_d;
  logic [15:0]          samp_q, samp_d;

  logic                 take;
  logic [W-1:0]         new_val;
  logic [4:0]           new_idx;
  logic                 label_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      label_q    <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      k_q        <= '0;
      pred_idx_q <= '0;
      pred_val_q <= '0;
      correct_q  <= 1'b0;
      exp_q      <= '0;
      lv_q       <= 1'b0;
      hit_q      <= '0;
      samp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      label_q    <= label_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      k_q        <= k_d;
      pred_idx_q <= pred_idx_d;
      pred_val_q <= pred_val_d;
      correct_q  <= correct_d;
      exp_q      <= exp_d;
      lv_q       <= lv_d;
      hit_q      <= hit_d;
      samp_q     <= samp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (k_q == 5'd21) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    take     = cap_q[k_q] > best_val_q;
    new_val  = take ? cap_q[k_q] : best_val_q;
    new_idx  = take ? k_q : best_idx_q;
    label_ok = label_q < 5'd22;
  end

  always_comb begin
    cap_d      = cap_q;
    label_d    = label_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    k_d        = k_q;
    pred_idx_d = pred_idx_q;
    pred_val_d = pred_val_q;
    correct_d  = correct_q;
    exp_d      = exp_q;
    lv_d       = lv_q;
    if (state_q == IDLE && start) begin
      cap_d      = scores;
      label_d    = label;
      best_val_d = scores[0];
      best_idx_d = '0;
      k_d        = 5'd1;
    end else if (state_q == SCAN) begin
      best_val_d = new_val;
      best_idx_d = new_idx;
      k_d        = k_q + 5'd1;
      // Results are latched on entry to DONE so they are valid while done is high.
      if (k_q == 5'd21) begin
        pred_idx_d = new_idx;
        pred_val_d = new_val;
        correct_d  = label_ok && (new_idx == label_q);
        lv_d       = label_ok;
        for (int unsigned i = 0; i < 22; i++) begin
          exp_d[i] = (label_ok && label_q == 5'(i)) ? TARGET_HI : TARGET_LO;
        end
      end
    end
  end

  // Counters advance on the edge closing the done cycle, so a clear there wins.
  always_comb begin
    hit_d  = hit_q;
    samp_d = samp_q;
    if (clear_stats) begin
      hit_d  = '0;
      samp_d = '0;
    end else if (state_q == DONE) begin
      if (samp_q != SAT_LIMIT) samp_d = samp_q + 16'd1;
      if (correct_q && hit_q != SAT_LIMIT) hit_d = hit_q + 16'd1;
    end
  end

  always_comb begin
    busy         = state_q != IDLE;
    done         = state_q == DONE;
    learn_valid  = lv_q && (state_q == DONE);
    pred_idx     = pred_idx_q;
    pred_val     = pred_val_q;
    correct      = correct_q;
    expected_out = exp_q;
    hit_count    = hit_q;
    sample_count = samp_q;
  end

endmodule

// File: tb/tb_layer22_argmax_scorer.sv
// Bench for layer22_argmax_scorer: cycle model of latency, argmax and counters,
// plus directed samples with hand-computed results.
module tb_layer22_argmax_scorer;

  localparam logic [15:0] SAT = 16'd6;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [21:0][7:0]   scores = '0;
  logic [4:0]         label = '0;
  logic               clear_stats = 1'b0;
  logic               busy, done, correct, learn_valid;
  logic [4:0]         pred_idx;
  logic [7:0]         pred_val;
  logic [21:0][7:0]   expected_out;
  logic [15:0]        hit_count, sample_count;

  int n_checks = 0;
  int n_pass = 0;

  layer22_argmax_scorer #(.SAT_LIMIT(SAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .scores(scores),
    .label(label), .clear_stats(clear_stats), .busy(busy), .done(done),
    .pred_idx(pred_idx), .pred_val(pred_val), .correct(correct),
    .expected_out(expected_out), .learn_valid(learn_valid),
    .hit_count(hit_count), .sample_count(sample_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: phase counts cycles since acceptance; results computed at acceptance.
  int               m_phase = 0;
  logic [4:0]       m_idx = '0, p_idx;
  logic [7:0]       m_val = '0, p_val;
  logic             m_cor = 1'b0, p_cor;
  logic             m_lv = 1'b0, p_lv;
  logic [21:0][7:0] m_exp = '0, p_exp;
  int               m_hit = 0, m_samp = 0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_phase = 0; m_idx = '0; m_val = '0; m_cor = 1'b0; m_lv = 1'b0;
      m_exp = '0; m_hit = 0; m_samp = 0;
    end else begin
      if (clear_stats) begin
        m_hit = 0; m_samp = 0;
      end else if (m_phase == 22) begin
        if (m_samp < int'(SAT)) m_samp++;
        if (m_cor && m_hit < int'(SAT)) m_hit++;
      end
      if (m_phase == 0 && start) begin
        p_idx = 0; p_val = scores[0];
        for (int i = 1; i < 22; i++)
          if (scores[i] > p_val) begin p_val = scores[i]; p_idx = 5'(i); end
        p_lv  = label < 22;
        p_cor = p_lv && (p_idx == label);
        p_exp = '0;
        if (p_lv) p_exp[label] = 8'hFF;
        m_phase = 1;
      end else if (m_phase == 21) begin
        m_phase = 22;
        m_idx = p_idx; m_val = p_val; m_cor = p_cor; m_lv = p_lv; m_exp = p_exp;
      end else if (m_phase == 22) m_phase = 0;
      else if (m_phase != 0) m_phase++;
    end
    #1;
    check("busy", busy, m_phase != 0);
    check("done", done, m_phase == 22);
    check("learn_valid", learn_valid, m_phase == 22 && m_lv);
    check("pred_idx", pred_idx, m_idx);
    check("pred_val", pred_val, m_val);
    check("correct", correct, m_cor);
    check("expected_out", expected_out, m_exp);
    check("hit_count", hit_count, 16'(m_hit));
    check("sample_count", sample_count, 16'(m_samp));
  end

  // Called on a negedge; returns on the negedge inside the done cycle.
  task automatic run_sample(input logic [21:0][7:0] s, input logic [4:0] l);
    int n = 0;
    while (busy && n < 50) begin @(negedge clock); n++; end
    check("idle_before_start", busy, 1'b0);
    scores = s; label = l; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin @(negedge clock); n++; end
    check("latency", 32'(n), 32'd22);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [21:0][7:0] s, e;
    int n;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pred_idx", pred_idx, 5'd0);
    check("rst_expected", expected_out, 176'd0);
    check("rst_counts", {hit_count, sample_count}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) s[i] = 8'(i * 4);
    run_sample(s, 5'd21);
    e = '0; e[21] = 8'hFF;
    check("t1_pred_idx", pred_idx, 5'd21);
    check("t1_pred_val", pred_val, 8'd84);
    check("t1_correct", correct, 1'b1);
    check("t1_learn_valid", learn_valid, 1'b1);
    check("t1_expected", expected_out, e);
    @(negedge clock);
    check("t1_counts", {hit_count, sample_count}, {16'd1, 16'd1});

    for (int i = 0; i < 22; i++) s[i] = 8'(i);
    s[3] = 8'd200; s[17] = 8'd200;
    run_sample(s, 5'd17);
    e = '0; e[17] = 8'hFF;
    check("t2_pred_idx", pred_idx, 5'd3);
    check("t2_pred_val", pred_val, 8'd200);
    check("t2_correct", correct, 1'b0);
    check("t2_learn_valid", learn_valid, 1'b1);
    check("t2_expected", expected_out, e);
    @(negedge clock);
    check("t2_counts", {hit_count, sample_count}, {16'd1, 16'd2});

    for (int i = 0; i < 22; i++) s[i] = 8'((i * 37) % 256);
    run_sample(s, 5'd25);
    check("t3_pred_idx", pred_idx, 5'd20);
    check("t3_pred_val", pred_val, 8'd228);
    check("t3_learn_valid", learn_valid, 1'b0);
    check("t3_expected", expected_out, 176'd0);
    @(negedge clock);
    check("t3_counts", {hit_count, sample_count}, {16'd1, 16'd3});

    for (int i = 0; i < 22; i++) s[i] = 8'(100 - i);
    scores = s; label = 5'd0; start = 1'b1;
    @(negedge clock);
    n = 1;
    scores = '1; label = 5'd9;
    while (!done && n < 40) begin
      start = (n == 5 || n == 10);
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    check("t4_latency", 32'(n), 32'd22);
    check("t4_pred_idx", pred_idx, 5'd0);
    check("t4_pred_val", pred_val, 8'd100);
    check("t4_correct", correct, 1'b1);
    @(negedge clock);
    check("t4_busy_after", busy, 1'b0);
    check("t4_counts", {hit_count, sample_count}, {16'd2, 16'd4});
    for (int i = 0; i < 22; i++) s[i] = 8'(i * 4);
    run_sample(s, 5'd21);
    @(negedge clock);
    check("t4_restart_counts", {hit_count, sample_count}, {16'd3, 16'd5});

    clear_stats = 1'b1;
    @(negedge clock);
    clear_stats = 1'b0;
    check("clear_counts", {hit_count, sample_count}, 32'd0);

    for (int j = 0; j < 7; j++) run_sample(s, 5'd21);
    @(negedge clock);
    check("sat_counts", {hit_count, sample_count}, {SAT, SAT});

    run_sample(s, 5'd21);
    clear_stats = 1'b1;
    @(negedge clock);
    clear_stats = 1'b0;
    check("clear_on_done", {hit_count, sample_count}, 32'd0);

    run_sample(s, 5'd21);
    @(negedge clock);
    check("pre_reset_counts", {hit_count, sample_count}, {16'd1, 16'd1});
    scores = s; label = 5'd21; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_done", done, 1'b0);
    check("mid_reset_counts", {hit_count, sample_count}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 22; i++) s[i] = 8'(21 - i);
    run_sample(s, 5'd0);
    check("post_reset_pred_idx", pred_idx, 5'd0);
    check("post_reset_pred_val", pred_val, 8'd21);
    @(negedge clock);
    check("post_reset_counts", {hit_count, sample_count}, {16'd1, 16'd1});

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer22_argmax_scorer.md
LAYER22_ARGMAX_SCORER -- requirements
Module: layer22_argmax_scorer

Interface
REQ-001 Parameter: TARGET_HI, default all-ones of zero2one_t, value driven on expected_out for the labelled class.
REQ-002 Parameter: TARGET_LO, default 0, value driven on expected_out for all other classes.
REQ-003 Port: clock  input  1  sole clock, rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  sample-valid pulse; accepted only in IDLE.
REQ-006 Port: scores  input  zero2one_t [22-1:0]  22-neuron layer outputs; sampled on accepted start.
REQ-007 Port: label  input  5  target class; sampled on accepted start.
REQ-008 Port: clear_stats  input  1  synchronous clear of both statistics counters.
REQ-009 Port: busy  output  1  high in SCAN and DONE.
REQ-010 Port: done  output  1  one-cycle result strobe.
REQ-011 Port: pred_idx  output  5  index of the maximum score.
REQ-012 Port: pred_val  output  zero2one_t  maximum score value.
REQ-013 Port: correct  output  1  pred_idx equals a valid label.
REQ-014 Port: expected_out  output  zero2one_t [22-1:0]  one-hot training target for the 22-neuron learning layer.
REQ-015 Port: learn_valid  output  1  one-cycle strobe, expected_out is a usable target.
REQ-016 Port: hit_count, sample_count  output  16 each  saturating statistics counters.

Function
REQ-017 FSM states SHALL be IDLE, SCAN and DONE; IDLE->SCAN on start; SCAN->DONE after index 21 is processed; DONE->IDLE unconditionally.
REQ-018 Accepted start SHALL register scores and label, set best_val=scores[0], best_idx=0 and scan pointer k=1.
REQ-019 Each SCAN cycle SHALL compare captured[k] against best_val unsigned, replace best on strict greater-than only, and increment k; a tie SHALL keep the lower index.
REQ-020 The SCAN cycle processing k=21 SHALL be the last; start accepted at edge t SHALL give done=1 during the cycle after edge t+21, 22 cycles of latency.
REQ-021 In DONE, pred_idx, pred_val, correct and expected_out SHALL be registered, and done SHALL be high for exactly that one cycle.
REQ-022 Result outputs SHALL hold until the next done.
REQ-023 start while busy=1 SHALL be ignored, with no capture and no effect; minimum start spacing is 23 cycles.
REQ-024 Valid label (0..21): expected_out[label]=TARGET_HI, all other entries TARGET_LO; learn_valid=1 with done.
REQ-025 Invalid label (22..31): expected_out all TARGET_LO, correct=0, learn_valid=0; sample_count SHALL still increment.
REQ-026 On done, sample_count SHALL increment by 1 and hit_count SHALL increment by 1 if correct; both SHALL saturate at 16'hFFFF.
REQ-027 clear_stats SHALL zero both counters and take priority over a simultaneous done increment; it SHALL not affect the FSM or result registers.
REQ-028 Changes on scores and label after capture SHALL not affect the in-flight result.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, busy=0, done=0, learn_valid=0, correct=0, pred_idx=0, pred_val=0, expected_out all 0, hit_count=0 and sample_count=0.
REQ-030 Reset asserted mid-SCAN SHALL abort the sample with no done and no counter change; after release the block SHALL idle until a new start.
REQ-031 Release SHALL be synchronous to clock, with the first start accepted on the first rising edge after release.

Verification
REQ-032 scores[i]=i*4 with 8-bit example, label=21, one start -> done exactly 22 cycles later; pred_idx=21, pred_val=84, correct=1, expected_out[21]=TARGET_HI and others 0, hit_count=1, sample_count=1.
REQ-033 scores[3]=scores[17]=max, label=17 -> pred_idx=3, correct=0, learn_valid=1, expected_out[17]=TARGET_HI, hit_count unchanged.
REQ-034 label=25 -> done=1, learn_valid=0, expected_out all 0, sample_count+1, hit_count+0.
REQ-035 start re-pulsed at cycles 5 and 10 after an accepted start with changed scores -> single done with the original result; next start accepted after busy falls.
REQ-036 Preload sample_count=16'hFFFF via repeated samples, then run one more -> sample_count stays FFFF; clear_stats coincident with done -> counters read 0.
REQ-037 reset_n pulsed low at SCAN cycle 10 -> busy=0 immediately, no done pulse, counters 0; a fresh start afterwards completes normally in 22 cycles.
